uniq_ser: RTL and testbench
===========================

UNIQ_SER -- requirements
Module: uniq_ser

Interface
REQ-001 Parameter ORDER, default 0: emission order; 0 = newest-first (in_1..in_4), 1 = oldest-first (in_4..in_1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 snap_en  input  1  snapshot-load strobe.
REQ-005 in_1..in_4  input  8 each, signed  tracker values; in_1 is the most recent.
REQ-006 vld_1..vld_4  input  1 each  per-entry valid flags for in_1..in_4.
REQ-007 data_out  output  8, signed  current emitted entry.
REQ-008 data_valid  output  1  data_out holds an entry offered to the consumer.
REQ-009 data_ready  input  1  consumer accepts data_out when data_valid is also high.
REQ-010 last  output  1  high with data_valid on the final entry of a snapshot.
REQ-011 busy  output  1  snapshot held, emission in progress.
REQ-012 count  output  3  number of valid entries in the most recently accepted snapshot (0..4).
REQ-013 snap_drop  output  1  one-cycle pulse when a snap_en was rejected.

Function
REQ-014 FSM states: IDLE, SEND; all outputs registered.
REQ-015 IDLE: busy=0, data_valid=0, last=0.
REQ-016 snap_en in IDLE: capture in_1..in_4 and a 4-bit valid mask at that edge; load count with the mask popcount.
REQ-017 Captured mask non-zero: go to SEND; data_valid=1 from the cycle after capture (latency 1); data_out = first valid entry in ORDER.
REQ-018 Captured mask zero: stay in IDLE; count=0; no output transfer.
REQ-019 Invalid entries are skipped; valid flags may be non-contiguous (e.g. vld=1010), and only flagged entries are emitted.
REQ-020 Transfer occurs on any edge where data_valid && data_ready; on transfer, advance to the next valid entry in ORDER with no idle cycle between entries.
REQ-021 data_out, last and data_valid hold stable while data_valid && !data_ready.
REQ-022 last = 1 exactly when the presented entry has no further valid entry after it in ORDER.
REQ-023 Transfer with last=1: return to IDLE; data_valid and busy drop on the next cycle.
REQ-024 snap_en on the same edge as the last=1 transfer is accepted; behave as in REQ-016/017 with no gap cycle.
REQ-025 snap_en in SEND without a last=1 transfer on that edge: ignore it, keep the held snapshot unchanged, and pulse snap_drop for one cycle.
REQ-026 Captured values are not deduplicated or reordered beyond ORDER; count changes only on an accepted snap_en.

Reset
REQ-027 rst_n low asserts immediately, regardless of clk: state=IDLE, data_out=0, data_valid=0, last=0, busy=0, count=0, snap_drop=0, captured values and mask cleared.
REQ-028 Reset mid-SEND abandons the snapshot; no entry is emitted after release until a new snap_en.
REQ-029 First snap_en is honoured on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package uniq_pkg holds DATA_W=8, NUM_ENTRIES=4, the state enum (IDLE, SEND) and the index type.
REQ-031 One sub-module, uniq_pick: combinational next-valid-index finder with inputs mask, current index and ORDER, outputs next index and a none-left flag; it drives advance logic and last.

Verification
REQ-032 ORDER=0, in=(5,-3,7,9), vld=1111, snap_en, ready=1 -> data_out 5,-3,7,9 on consecutive cycles; last on 9; count=4; busy drops after 9.
REQ-033 ORDER=1, same inputs, vld_2=0, vld_4=0 (mask 0101) -> data_out 7 then 5; last on 5; count=2.
REQ-034 ready held low 3 cycles on the first entry -> data_out=5, data_valid=1 and last=0 stable throughout; emission then resumes.
REQ-035 snap_en mid-SEND (second of four) -> snap_drop pulses for one cycle and the remaining entries are unchanged; snap_en coincident with the last transfer -> new snapshot starts the next cycle with no gap.
REQ-036 vld=0000, snap_en -> count=0, data_valid never rises, busy stays 0.
REQ-037 rst_n low during the third entry -> all outputs 0 asynchronously; nothing emitted after release until a new snap_en.

Source files
------------

// File: rtl/uniq_pkg.sv
// Shared types and constants for the snapshot serializer: entry width, entry
// count, FSM states and small mask helpers.
package uniq_pkg;
    localparam int DATA_W      = 8;
    localparam int NUM_ENTRIES = 4;
    localparam int IDX_W       = 2;

    typedef enum logic {IDLE, SEND} state_t;
    typedef logic [IDX_W-1:0]         idx_t;
    typedef logic [NUM_ENTRIES-1:0]   mask_t;
    typedef logic signed [DATA_W-1:0] data_t;

    function automatic logic [2:0] popcount(input mask_t m);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            n = n + {2'b00, m[i]};
        end
        return n;
    endfunction

    function automatic mask_t onehot(input idx_t i);
        return mask_t'(1) << i;
    endfunction
endpackage

// File: rtl/uniq_ser_if.sv
// Snapshot load side and valid/ready emission side of the serializer.
interface uniq_ser_if;
    import uniq_pkg::*;

    logic  snap_en;
    data_t in_1, in_2, in_3, in_4;
    logic  vld_1, vld_2, vld_3, vld_4;
    data_t data_out;
    logic  data_valid;
    logic  data_ready;
    logic  last;
    logic  busy;
    logic  [2:0] count;
    logic  snap_drop;

    modport slave (
        input  snap_en, in_1, in_2, in_3, in_4, vld_1, vld_2, vld_3, vld_4, data_ready,
        output data_out, data_valid, last, busy, count, snap_drop
    );

    modport master (
        output snap_en, in_1, in_2, in_3, in_4, vld_1, vld_2, vld_3, vld_4, data_ready,
        input  data_out, data_valid, last, busy, count, snap_drop
    );
endinterface

// File: rtl/uniq_pick.sv
// Finds the nearest flagged entry strictly after cur_i in emission order;
// none_o is set when no flagged entry follows.
module uniq_pick
    import uniq_pkg::*;
#(
    parameter int ORDER = 0
) (
    input  mask_t mask_i,
    input  idx_t  cur_i,
    output idx_t  next_o,
    output logic  none_o
);
    always_comb begin
        int pos;
        next_o = cur_i;
        none_o = 1'b1;
        pos    = 0;
        // Scan farthest to nearest so the nearest hit is the one that sticks.
        for (int k = NUM_ENTRIES - 1; k >= 1; k--) begin
            pos = (ORDER == 0) ? int'(cur_i) + k : int'(cur_i) - k;
            if (pos >= 0 && pos < NUM_ENTRIES) begin
                if (mask_i[pos[IDX_W-1:0]]) begin
                    next_o = pos[IDX_W-1:0];
                    none_o = 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/uniq_ser.sv
// Captures a 4-entry tracker snapshot and streams its flagged entries over a
// valid/ready port, newest-first (ORDER=0) or oldest-first (ORDER=1).
module uniq_ser
    import uniq_pkg::*;
#(
    parameter int ORDER = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    uniq_ser_if.slave  bus
);
    localparam idx_t START = (ORDER == 0) ? idx_t'(0) : idx_t'(NUM_ENTRIES - 1);

    state_t     state_q, state_d;
    data_t      data_q [NUM_ENTRIES];
    data_t      data_d [NUM_ENTRIES];
    mask_t      rem_q, rem_d;
    idx_t       idx_q, idx_d;
    data_t      data_out_q, data_out_d;
    logic       last_q, last_d;
    logic [2:0] count_q, count_d;
    logic       drop_q, drop_d;

    data_t cap_data [NUM_ENTRIES];
    mask_t cap_mask;
    idx_t  scan_next, first_idx, next_idx;
    logic  scan_none, none_left;
    logic  cap_empty, xfer, done, accept;
    mask_t first_rem, next_rem;

    assign cap_data[0] = bus.in_1;
    assign cap_data[1] = bus.in_2;
    assign cap_data[2] = bus.in_3;
    assign cap_data[3] = bus.in_4;
    assign cap_mask    = {bus.vld_4, bus.vld_3, bus.vld_2, bus.vld_1};

    uniq_pick #(.ORDER(ORDER)) u_first (
        .mask_i (cap_mask),
        .cur_i  (START),
        .next_o (scan_next),
        .none_o (scan_none)
    );

    // rem_q only ever holds entries that follow idx_q, so its nearest hit is the next entry.
    uniq_pick #(.ORDER(ORDER)) u_next (
        .mask_i (rem_q),
        .cur_i  (idx_q),
        .next_o (next_idx),
        .none_o (none_left)
    );

    assign first_idx = cap_mask[START] ? START : scan_next;
    assign cap_empty = !cap_mask[START] && scan_none;
    assign first_rem = cap_mask & ~onehot(first_idx);
    assign next_rem  = rem_q & ~onehot(next_idx);

    assign xfer   = (state_q == SEND) && bus.data_ready;
    assign done   = xfer && none_left;
    assign accept = bus.snap_en && ((state_q == IDLE) || done);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        data_out_d = data_out_q;
        last_d     = last_q;
        count_d    = count_q;
        drop_d     = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            data_d[i] = data_q[i];
        end

        if (accept) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                data_d[i] = cap_data[i];
            end
            count_d = popcount(cap_mask);
            if (cap_empty) begin
                state_d = IDLE;
                rem_d   = '0;
                last_d  = 1'b0;
            end else begin
                state_d    = SEND;
                idx_d      = first_idx;
                data_out_d = cap_data[first_idx];
                rem_d      = first_rem;
                last_d     = (first_rem == '0);
            end
        end else begin
            // Any snap_en not accepted here arrived mid-snapshot.
            drop_d = bus.snap_en;
            if (done) begin
                state_d = IDLE;
                last_d  = 1'b0;
            end else if (xfer) begin
                idx_d      = next_idx;
                data_out_d = data_q[next_idx];
                rem_d      = next_rem;
                last_d     = (next_rem == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            idx_q      <= '0;
            data_out_q <= '0;
            last_q     <= 1'b0;
            count_q    <= '0;
            drop_q     <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            data_out_q <= data_out_d;
            last_q     <= last_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = (state_q == SEND);
    assign bus.busy       = (state_q == SEND);
    assign bus.last       = last_q;
    assign bus.count      = count_q;
    assign bus.snap_drop  = drop_q;
endmodule

// File: tb/tb_uniq_ser.sv
// Drives both emission orders with identical stimulus and checks every cycle
// against a queue-based model of the snapshot serializer.
module tb_uniq_ser;
    import uniq_pkg::*;

    typedef logic signed [7:0] s8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uniq_ser_if b0 ();
    uniq_ser_if b1 ();

    uniq_ser #(.ORDER(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    uniq_ser #(.ORDER(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    s8          in_v [4];
    logic [3:0] vm;
    logic       se, rdy;

    assign b0.in_1 = in_v[0];  assign b1.in_1 = in_v[0];
    assign b0.in_2 = in_v[1];  assign b1.in_2 = in_v[1];
    assign b0.in_3 = in_v[2];  assign b1.in_3 = in_v[2];
    assign b0.in_4 = in_v[3];  assign b1.in_4 = in_v[3];
    assign b0.vld_1 = vm[0];   assign b1.vld_1 = vm[0];
    assign b0.vld_2 = vm[1];   assign b1.vld_2 = vm[1];
    assign b0.vld_3 = vm[2];   assign b1.vld_3 = vm[2];
    assign b0.vld_4 = vm[3];   assign b1.vld_4 = vm[3];
    assign b0.snap_en = se;    assign b1.snap_en = se;
    assign b0.data_ready = rdy; assign b1.data_ready = rdy;

    // Model: the entries still to be emitted, front = currently presented.
    s8  mq [2][$];
    int mcount [2];
    bit mdrop [2];
    s8  log_q [2][$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, $signed(act), $signed(exp));
        end
    endtask

    task automatic get_outs(input int o, output s8 d, output logic v, output logic l,
                            output logic bz, output logic [2:0] c, output logic dr);
        if (o == 0) begin
            d = b0.data_out; v = b0.data_valid; l = b0.last;
            bz = b0.busy; c = b0.count; dr = b0.snap_drop;
        end else begin
            d = b1.data_out; v = b1.data_valid; l = b1.last;
            bz = b1.busy; c = b1.count; dr = b1.snap_drop;
        end
    endtask

    task automatic model_step();
        for (int o = 0; o < 2; o++) begin
            bit was_empty, xfer, lastx, accept;
            int n;
            was_empty = (mq[o].size() == 0);
            xfer      = !was_empty && rdy;
            lastx     = xfer && (mq[o].size() == 1);
            if (xfer) void'(mq[o].pop_front());
            accept   = se && (was_empty || lastx);
            mdrop[o] = se && !accept;
            if (accept) begin
                mq[o].delete();
                n = 0;
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (o == 0) ? k : 3 - k;
                    if (vm[idx]) begin
                        mq[o].push_back(in_v[idx]);
                        n++;
                    end
                end
                mcount[o] = n;
            end
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 2; o++) begin
            mq[o].delete();
            mcount[o] = 0;
            mdrop[o]  = 1'b0;
        end
    endtask

    task automatic compare();
        for (int o = 0; o < 2; o++) begin
            s8 d; logic v, l, bz, dr; logic [2:0] c; bit ev;
            get_outs(o, d, v, l, bz, c, dr);
            ev = (mq[o].size() != 0);
            chk($sformatf("o%0d_valid", o), 32'(v), 32'(ev));
            chk($sformatf("o%0d_busy", o), 32'(bz), 32'(ev));
            chk($sformatf("o%0d_last", o), 32'(l), 32'(ev && mq[o].size() == 1));
            chk($sformatf("o%0d_count", o), 32'(c), 32'(mcount[o]));
            chk($sformatf("o%0d_drop", o), 32'(dr), 32'(mdrop[o]));
            if (ev) chk($sformatf("o%0d_data", o), 32'(d), 32'(mq[o][0]));
        end
    endtask

    // Drive one cycle; inputs change at the falling edge and outputs are compared there.
    task automatic cyc(input bit s, input bit r);
        se  = s;
        rdy = r;
        if (b0.data_valid && r) log_q[0].push_back(b0.data_out);
        if (b1.data_valid && r) log_q[1].push_back(b1.data_out);
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare();
        $display("cyc t=%0t se=%0b rdy=%0b vm=%b o0: v=%0b d=%0d l=%0b  o1: v=%0b d=%0d l=%0b",
                 $time, s, r, vm, b0.data_valid, b0.data_out, b0.last,
                 b1.data_valid, b1.data_out, b1.last);
    endtask

    task automatic chk_log(input int o, input string nm, input s8 exp [$]);
        chk({nm, "_len"}, 32'(log_q[o].size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_q[o].size(); i++) begin
            chk($sformatf("%s_%0d", nm, i), 32'(log_q[o][i]), 32'(exp[i]));
        end
    endtask

    task automatic clear_logs();
        log_q[0].delete();
        log_q[1].delete();
    endtask

    initial begin
        s8 e [$];
        se = 1'b0; rdy = 1'b0; vm = 4'b0000;
        for (int i = 0; i < 4; i++) in_v[i] = '0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compare();
        rst_n = 1'b1;

        // Full snapshot, ready always high.
        in_v[0] = 5; in_v[1] = -3; in_v[2] = 7; in_v[3] = 9; vm = 4'b1111;
        clear_logs();
        cyc(1, 1);
        repeat (5) cyc(0, 1);
        e = '{5, -3, 7, 9};  chk_log(0, "full_o0", e);
        e = '{9, 7, -3, 5};  chk_log(1, "full_o1", e);
        chk("full_count", 32'(b0.count), 32'd4);

        // Sparse mask 0101.
        vm = 4'b0101;
        clear_logs();
        cyc(1, 1);
        repeat (3) cyc(0, 1);
        e = '{7, 5};  chk_log(1, "sparse_o1", e);
        e = '{5, 7};  chk_log(0, "sparse_o0", e);
        chk("sparse_count", 32'(b1.count), 32'd2);

        // Backpressure on the first entry.
        vm = 4'b1111;
        clear_logs();
        cyc(1, 0);
        repeat (3) begin
            cyc(0, 0);
            chk("stall_data", 32'(b0.data_out), 32'd5);
            chk("stall_valid", 32'(b0.data_valid), 32'd1);
            chk("stall_last", 32'(b0.last), 32'd0);
        end
        repeat (5) cyc(0, 1);
        e = '{5, -3, 7, 9};  chk_log(0, "stall_o0", e);

        // snap_en mid-snapshot is dropped; snap_en on the last transfer chains.
        clear_logs();
        cyc(1, 1);
        cyc(0, 1);
        cyc(1, 1);
        chk("drop_pulse", 32'(b0.snap_drop), 32'd1);
        in_v[0] = 11; in_v[1] = 22; in_v[2] = -33; in_v[3] = 44;
        cyc(0, 1);
        chk("drop_once", 32'(b0.snap_drop), 32'd0);
        cyc(1, 1);
        chk("nogap_valid", 32'(b0.data_valid), 32'd1);
        chk("nogap_data", 32'(b0.data_out), 32'd11);
        repeat (5) cyc(0, 1);
        e = '{5, -3, 7, 9, 11, 22, -33, 44};  chk_log(0, "chain_o0", e);

        // Empty mask.
        vm = 4'b0000;
        cyc(1, 1);
        chk("empty_count", 32'(b0.count), 32'd0);
        chk("empty_valid", 32'(b0.data_valid), 32'd0);
        repeat (2) cyc(0, 1);

        // Asynchronous reset during the third entry.
        vm = 4'b1111;
        in_v[0] = 1; in_v[1] = 2; in_v[2] = 3; in_v[3] = 4;
        cyc(1, 1);
        cyc(0, 1);
        cyc(0, 1);
        chk("pre_rst_data", 32'(b0.data_out), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data", 32'(b0.data_out), 32'd0);
        chk("rst_valid", 32'(b0.data_valid), 32'd0);
        chk("rst_last", 32'(b1.last), 32'd0);
        chk("rst_busy", 32'(b1.busy), 32'd0);
        chk("rst_count", 32'(b0.count), 32'd0);
        model_reset();
        se = 1'b0;
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        repeat (4) cyc(0, 1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) in_v[i] = s8'($urandom_range(0, 255));
            vm = 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
